// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: CHUNK bits resolved per stage, carry registered between stages.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic                         advance;
  logic [STAGES-1:0]            vld;
  logic [STAGES-1:0]            cry;
  logic [STAGES-1:0][WIDTH-1:0] opa;
  logic [STAGES-1:0][WIDTH-1:0] opb;
  logic [STAGES-1:0][WIDTH-1:0] res;
  logic                         unused_skew;

  // Whole pipe freezes while a result is waiting on downstream.
  assign advance   = !vld[STAGES-1] || out_ready;
  assign in_ready  = advance && !rst;
  assign out_valid = vld[STAGES-1];
  assign sum       = res[STAGES-1];
  assign cout      = cry[STAGES-1];

  // Operand copies leaving the last stage have no consumer.
  assign unused_skew = ^{opa[STAGES-1], opb[STAGES-1]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;
    logic [CHUNK:0]   s;
    logic             v_q, v_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;

    if (k == 0) begin : g_src
      // Subtract folds into the add as a + ~b + ~cin.
      assign v_in = in_valid && in_ready;
      assign c_in = sub ? ~cin : cin;
      assign a_in = a;
      assign b_in = sub ? ~b : b;
      assign r_in = '0;
    end else begin : g_src
      assign v_in = vld[k-1];
      assign c_in = cry[k-1];
      assign a_in = opa[k-1];
      assign b_in = opb[k-1];
      assign r_in = res[k-1];
    end

    always_comb begin
      v_d = v_q;
      c_d = c_q;
      a_d = a_q;
      b_d = b_q;
      r_d = r_q;
      s   = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]}
          + (CHUNK+1)'(c_in);
      if (advance) begin
        v_d                   = v_in;
        c_d                   = s[CHUNK];
        a_d                   = a_in;
        b_d                   = b_in;
        r_d                   = r_in;
        r_d[k*CHUNK +: CHUNK] = s[CHUNK-1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        r_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        a_q <= a_d;
        b_q <= b_d;
        r_q <= r_d;
      end
    end

    assign vld[k] = v_q;
    assign cry[k] = c_q;
    assign opa[k] = a_q;
    assign opb[k] = b_q;
    assign res[k] = r_q;

`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES-1) begin : g_ovf
      logic ovf_q, ovf_d;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_comb begin
        ovf_d = ovf_q;
        if (advance) begin
          ovf_d = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ s[CHUNK-1] ^ s[CHUNK];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end

      assign ovf = ovf_q;
    end
`endif
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=16, CHUNK=4): vector table, latency, streaming, stall and reset.
module tb_pipe_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned DEPTH = 64;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf_v;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  res_t obs_r   [DEPTH];
  int   obs_cyc [DEPTH];
  int   obs_n   = 0;
  res_t exp_r   [DEPTH];
  int   exp_n   = 0;
  int   rd      = 0;
  vec_t vecs    [14];

`ifdef PIPE_ADDER_OVF_EN
  logic ovf;
  assign ovf_v = ovf;
`else
  assign ovf_v = 1'b0;
`endif

  pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer with the cycle it happened in.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && obs_n < DEPTH) begin
      obs_r[obs_n]   <= {sum, cout, ovf_v};
      obs_cyc[obs_n] <= cyc;
      obs_n          <= obs_n + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic res_t mkr(input logic [15:0] s, input logic c, input logic o);
    res_t r;
    r.sum  = s;
    r.cout = c;
    r.ovf  = o;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [15:0] x, input logic [15:0] y, input logic c,
                               input logic s, input logic [15:0] es, input logic ec,
                               input logic eo);
    vec_t v;
    v.a   = x;
    v.b   = y;
    v.cin = c;
    v.sub = s;
    v.exp = mkr(es, ec, eo);
    return v;
  endfunction

  // Integer reference: exact unsigned and signed results, then reduce.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic c,
                                 input logic s);
    int   u;
    int   sv;
    res_t r;
    if (!s) begin
      u      = int'(x) + int'(y) + int'(c);
      sv     = int'($signed(x)) + int'($signed(y)) + int'(c);
      r.cout = u[16];
    end else begin
      u      = int'(x) - int'(y) - int'(c);
      sv     = int'($signed(x)) - int'($signed(y)) - int'(c);
      r.cout = (u >= 0);
    end
    r.sum = u[15:0];
    r.ovf = (sv > 32767) || (sv < -32768);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c,
                      input logic s, input res_t e);
    int t;
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      exp_r[exp_n] = e;
      exp_n++;
    end
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge: result must show after exactly three more edges.
  task automatic latency(input string name, input res_t e);
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check({name, "_valid"}, 32'(out_valid), 32'(j == 3));
      if (j == 3) begin
        check({name, "_sum"}, 32'(sum), 32'(e.sum));
        check({name, "_cout"}, 32'(cout), 32'(e.cout));
      end
      tick();
    end
  endtask

  task automatic expect_all(input string name);
    int t;
    t = 0;
    while (obs_n < exp_n && t < 40) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check({name, "_count"}, 32'(obs_n), 32'(exp_n));
    for (int i = rd; i < exp_n && i < obs_n; i++) begin
      check({name, "_sum"}, 32'(obs_r[i].sum), 32'(exp_r[i].sum));
      check({name, "_cout"}, 32'(obs_r[i].cout), 32'(exp_r[i].cout));
`ifdef PIPE_ADDER_OVF_EN
      check({name, "_ovf"}, 32'(obs_r[i].ovf), 32'(exp_r[i].ovf));
`endif
    end
    exp_n = obs_n;
    rd    = obs_n;
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    //             a         b         cin   sub   sum       cout  ovf
    vecs[0]  = mkv(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[1]  = mkv(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    vecs[2]  = mkv(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    vecs[3]  = mkv(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[4]  = mkv(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    vecs[5]  = mkv(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    vecs[6]  = mkv(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    vecs[7]  = mkv(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vecs[8]  = mkv(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    vecs[9]  = mkv(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    vecs[10] = mkv(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    vecs[11] = mkv(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    vecs[12] = mkv(16'h8000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    vecs[13] = mkv(16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef PIPE_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Full-width carry ripple with exact latency and a one-cycle out_valid pulse.
    send(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, vecs[0].exp);
    latency("ripple", vecs[0].exp);
    expect_all("ripple");

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
    end
    in_valid = 1'b0;
    expect_all("table");

    base = exp_n;
    for (int i = 0; i < 8; i++) begin
      send(16'(i), 16'(i), 1'b0, 1'b0, mkr(16'(2 * i), 1'b0, 1'b0));
    end
    in_valid = 1'b0;
    expect_all("stream");
    for (int i = 1; i < 8; i++) begin
      check("stream_gap", 32'(obs_cyc[base + i] - obs_cyc[base + i - 1]), 32'd1);
    end

    // Fill the pipe against a stalled sink, then hold for three cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(16'(16'h0F00 + i * 16'h0123), 16'h00FF, 1'(i % 2), 1'b0,
           model(16'(16'h0F00 + i * 16'h0123), 16'h00FF, 1'(i % 2), 1'b0));
    end
    a        = 16'h2000;
    b        = 16'h3001;
    cin      = 1'b1;
    sub      = 1'b1;
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_sum", 32'(sum), 32'(model(16'h0F00, 16'h00FF, 1'b0, 1'b0).sum));
      tick();
    end
    out_ready = 1'b1;
    send(16'h2000, 16'h3001, 1'b1, 1'b1, model(16'h2000, 16'h3001, 1'b1, 1'b1));
    in_valid = 1'b0;
    expect_all("bp");

    // Reset with three beats in flight: none of them may surface.
    for (int i = 0; i < 3; i++) begin
      send(16'(16'h4000 + i), 16'h0010, 1'b0, 1'b0, mkr(16'(16'h4010 + i), 1'b0, 1'b0));
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    exp_n = obs_n;
    rd    = obs_n;
    #1;
    send(16'h0102, 16'h0304, 1'b0, 1'b0, mkr(16'h0406, 1'b0, 1'b0));
    latency("post_rst", mkr(16'h0406, 1'b0, 1'b0));
    expect_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
